// File: rtl/divresult_bcd_display_pkg.sv
// Purpose: shared FSM encodings, segment codes and BCD helpers for the divider result display.
// Latency: combinational helpers only.
// Backpressure: none; no handshakes live here.
package divider_pkg;

  // Conversion FSM encodings
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV_Q = 2'd1;
  localparam logic [1:0] CONV_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Decimal digit to segment pattern; anything out of range renders blank
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 9-bit magnitude of a signed byte; -128 maps to 128 rather than wrapping to 0
  function automatic logic [8:0] mag9(input logic [7:0] v);
    return v[7] ? (9'd0 - {v[7], v}) : {1'b0, v};
  endfunction

  // One double-dabble iteration on {bcd[11:0], shift[8:0]}: correct nibbles >=5, shift left
  function automatic logic [20:0] dabble_step(input logic [20:0] w);
    logic [20:0] t;
    t = w;
    for (int k = 0; k < 3; k++) begin
      if (t[9 + 4*k +: 4] >= 4'd5) t[9 + 4*k +: 4] = t[9 + 4*k +: 4] + 4'd3;
    end
    return {t[19:0], 1'b0};
  endfunction

endpackage

// File: rtl/divresult_bcd_display_if.sv
// Purpose: bundles the divider result inputs and the display/busy outputs.
// Latency: wiring only.
// Backpressure: none; the display samples whenever it is idle.
interface divresult_bcd_display_if;
  logic [7:0] i_quo;
  logic [7:0] i_rem;
  logic       o_busy;
  logic [7:0] o_an;
  logic [6:0] o_seg;

  modport master (output i_quo, output i_rem, input o_busy, input o_an, input o_seg);
  modport slave  (input i_quo, input i_rem, output o_busy, output o_an, output o_seg);
endinterface

// File: rtl/divresult_bcd_display_bcd_dabble_8.sv
// Purpose: sequential binary-to-BCD converter, one double-dabble iteration per cycle.
// Latency: i_start cycle performs iteration 1; o_done pulses 8 cycles after i_start.
// Backpressure: none; i_start restarts immediately, o_bcd holds until the next start.
module bcd_dabble_8
  import divider_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [8:0]  i_mag,
  output logic [11:0] o_bcd,
  output logic        o_done
);

  logic [20:0] r_work;
  logic [2:0]  r_cnt;
  logic        r_run;
  logic        r_done;

  // Load folds into the first iteration so back-to-back conversions need no idle cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_work <= dabble_step({11'd0, i_mag, 1'b0});
      r_cnt  <= 3'd1;
      r_run  <= 1'b1;
      r_done <= 1'b0;
    end else if (r_run) begin
      r_work <= dabble_step(r_work);
      r_cnt  <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_bcd  = r_work[20:9];
  assign o_done = r_done;

endmodule

// File: rtl/divresult_bcd_display.sv
// Purpose: converts signed quotient/remainder to sign+3 BCD digits and scans an 8-digit 7-seg display.
// Latency: change seen in IDLE cycle N -> busy N+1..N+17, new digits shown from N+18.
// Backpressure: none; inputs that move mid-conversion are picked up on the next IDLE pass.
module divresult_bcd_display
  import divider_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  divresult_bcd_display_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Conversion control
  logic [1:0]  r_state;
  logic [2:0]  r_it;
  logic [15:0] r_snap;
  logic        r_force;
  logic        r_busy;
  logic        r_q_neg;
  logic [11:0] r_q_bcd;

  // Displayed values
  logic        r_dq_neg;
  logic [11:0] r_dq_bcd;
  logic        r_dr_neg;
  logic [11:0] r_dr_bcd;

  // Scan
  logic [CNT_W-1:0] r_ref;
  logic [2:0]       r_idx;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;

  logic        w_q_neg;
  logic        w_r_neg;
  logic        w_conv;
  logic        w_dab_start;
  logic [8:0]  w_dab_mag;
  logic [11:0] w_dab_bcd;
  logic        w_dab_done;
  logic        w_upd;
  logic        w_nq_neg;
  logic [11:0] w_nq_bcd;
  logic        w_nr_neg;
  logic [11:0] w_nr_bcd;
  logic        w_ref_wrap;
  logic [2:0]  w_idx_nxt;
  logic        w_sel_neg;
  logic [11:0] w_sel_bcd;
  logic [6:0]  w_seg_nxt;

  assign w_q_neg     = r_snap[15];
  assign w_r_neg     = r_snap[7];
  assign w_conv      = (r_state == CONV_Q) || (r_state == CONV_R);
  assign w_dab_start = w_conv && (r_it == 3'd0);
  assign w_dab_mag   = (r_state == CONV_Q) ? mag9(r_snap[15:8]) : mag9(r_snap[7:0]);

  bcd_dabble_8 u_dabble (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_dab_start),
    .i_mag   (w_dab_mag),
    .o_bcd   (w_dab_bcd),
    .o_done  (w_dab_done)
  );

  // Change detect in IDLE, then 8 quotient + 8 remainder iterations and a commit cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_it    <= '0;
      r_snap  <= '0;
      r_force <= 1'b1;
      r_busy  <= 1'b0;
      r_q_neg <= 1'b0;
      r_q_bcd <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (({bus.i_quo, bus.i_rem} != r_snap) || r_force) begin
            r_snap  <= {bus.i_quo, bus.i_rem};
            r_force <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CONV_Q;
          end
        end
        CONV_Q: begin
          r_it <= r_it + 3'd1;
          if (r_it == 3'd7) r_state <= CONV_R;
        end
        CONV_R: begin
          // The converter's done pulse lands on the first remainder cycle: park the quotient
          if (w_dab_done) begin
            r_q_neg <= w_q_neg;
            r_q_bcd <= w_dab_bcd;
          end
          r_it <= r_it + 3'd1;
          if (r_it == 3'd7) r_state <= DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Both halves switch together in DONE so a half-updated pair is never visible
  assign w_upd    = (r_state == DONE);
  assign w_nq_neg = w_upd ? r_q_neg   : r_dq_neg;
  assign w_nq_bcd = w_upd ? r_q_bcd   : r_dq_bcd;
  assign w_nr_neg = w_upd ? w_r_neg   : r_dr_neg;
  assign w_nr_bcd = w_upd ? w_dab_bcd : r_dr_bcd;

  // Display registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dq_neg <= 1'b0;
      r_dq_bcd <= '0;
      r_dr_neg <= 1'b0;
      r_dr_bcd <= '0;
    end else begin
      r_dq_neg <= w_nq_neg;
      r_dq_bcd <= w_nq_bcd;
      r_dr_neg <= w_nr_neg;
      r_dr_bcd <= w_nr_bcd;
    end
  end

  assign w_ref_wrap = (r_ref == CNT_W'(REFRESH_DIV - 1));
  assign w_idx_nxt  = w_ref_wrap ? (r_idx + 3'd1) : r_idx;

  // Segment pattern for the digit about to be lit, with leading-zero blanking
  always_comb begin
    w_sel_neg = w_idx_nxt[2] ? w_nq_neg : w_nr_neg;
    w_sel_bcd = w_idx_nxt[2] ? w_nq_bcd : w_nr_bcd;
    w_seg_nxt = SEG_BLANK;
    case (w_idx_nxt[1:0])
      2'd0: w_seg_nxt = seg_digit(w_sel_bcd[3:0]);
      2'd1: w_seg_nxt = (w_sel_bcd[11:4] == 8'd0) ? SEG_BLANK : seg_digit(w_sel_bcd[7:4]);
      2'd2: w_seg_nxt = (w_sel_bcd[11:8] == 4'd0) ? SEG_BLANK : seg_digit(w_sel_bcd[11:8]);
      default: w_seg_nxt = w_sel_neg ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  // Refresh counter and registered anode/segment drive
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref <= '0;
      r_idx <= '0;
      r_an  <= 8'hFE;
      r_seg <= SEG_0;
    end else begin
      r_ref <= w_ref_wrap ? '0 : (r_ref + CNT_W'(1));
      r_idx <= w_idx_nxt;
      r_an  <= ~(8'd1 << w_idx_nxt);
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_an   = r_an;
  assign bus.o_seg  = r_seg;

endmodule

// File: tb/tb_divresult_bcd_display.sv
// Purpose: scoreboard bench for divresult_bcd_display with a fast refresh.
// Latency: checks 17-cycle busy window and that digits are right once busy drops.
// Backpressure: n/a; stimulus waits for each conversion before the next.
module tb_divresult_bcd_display;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divresult_bcd_display_if bus();

  divresult_bcd_display #(.REFRESH_DIV(RD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [55:0] exp_q[$];
  logic mon_en = 1'b0;
  int mix_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig7(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // {sign, hundreds, tens, ones} segments for one signed byte, from integer arithmetic
  function automatic logic [27:0] half(input logic [7:0] v);
    int s, m, h, t, o;
    logic [6:0] sg, hs, ts, os;
    s = $signed(v);
    m = (s < 0) ? -s : s;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    sg = (s < 0) ? 7'h3F : 7'h7F;
    hs = (h == 0) ? 7'h7F : dig7(h);
    ts = (h == 0 && t == 0) ? 7'h7F : dig7(t);
    os = dig7(o);
    return {sg, hs, ts, os};
  endfunction

  function automatic logic [55:0] model(input logic [7:0] q, input logic [7:0] r);
    return {half(q), half(r)};
  endfunction

  // Any ones digit of the quotient seen during the mid-conversion test must be old 8, 5 or 12's 2
  always @(negedge clk) begin
    if (mon_en && bus.o_an == 8'hEF &&
        !(bus.o_seg == 7'h00 || bus.o_seg == 7'h12 || bus.o_seg == 7'h24))
      mix_bad++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog n_vec=%0d n_err=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic wait_rise(output int lat);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.o_busy) break;
    end
  endtask

  task automatic wait_fall(input int start, output int len);
    len = start;
    while (len < 40) begin
      @(negedge clk);
      if (!bus.o_busy) break;
      len++;
    end
  endtask

  task automatic scan_check(input string tag);
    logic [6:0]  got [8];
    logic [7:0]  seen;
    logic [55:0] e;
    int bad;
    seen = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) got[i] = 7'h7F;
    for (int c = 0; c < 8 * RD; c++) begin
      if (c > 0) @(negedge clk);
      if ($countones(~bus.o_an) != 1) bad++;
      else begin
        for (int i = 0; i < 8; i++) begin
          if (!bus.o_an[i]) begin
            got[i] = bus.o_seg;
            seen[i] = 1'b1;
          end
        end
      end
    end
    chk({tag, "_onehot"}, bad, 0);
    chk({tag, "_cover"}, {24'd0, seen}, 32'hFF);
    chk({tag, "_sb"}, exp_q.size(), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_an%0d", tag, i), {25'd0, got[i]}, {25'd0, e[i*7 +: 7]});
  endtask

  task automatic run_vec(input string tag, input logic [7:0] q, input logic [7:0] r);
    int lat, len;
    bus.i_quo = q;
    bus.i_rem = r;
    exp_q.push_back(model(q, r));
    wait_rise(lat);
    chk({tag, "_lat"}, lat, 1);
    wait_fall(1, len);
    chk({tag, "_len"}, len, 17);
    scan_check(tag);
  endtask

  initial begin
    int lat, len;
    logic [7:0] e_an;

    // 1: reset state and forced conversion after release
    bus.i_quo = 8'h00;
    bus.i_rem = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_an", bus.o_an, 8'hFE);
    chk("rst_seg", bus.o_seg, 7'h40);
    exp_q.push_back(model(8'h00, 8'h00));
    rst = 1'b0;
    wait_rise(lat);
    chk("t1_lat", lat, 1);
    wait_fall(1, len);
    chk("t1_len", len, 17);
    scan_check("t1");

    // 2-4: positive, negative, and the -128 corner
    run_vec("t2", 8'h07, 8'h01);
    run_vec("t3", 8'hF9, 8'hFF);
    run_vec("t4", 8'h80, 8'h00);

    // 5: input change at conversion cycle 5 triggers a follow-up conversion
    mon_en = 1'b1;
    bus.i_quo = 8'h05;
    bus.i_rem = 8'h00;
    wait_rise(lat);
    chk("t5_lat", lat, 1);
    repeat (4) @(negedge clk);
    bus.i_quo = 8'h0C;
    exp_q.push_back(model(8'h0C, 8'h00));
    wait_fall(5, len);
    chk("t5_len1", len, 17);
    wait_rise(lat);
    chk("t5_gap", lat, 1);
    wait_fall(1, len);
    chk("t5_len2", len, 17);
    scan_check("t5");
    mon_en = 1'b0;
    chk("t5_nomix", mix_bad, 0);

    // 6: free-running scan order and hold time
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_an == 8'h7F) break;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.o_an != 8'h7F) break;
    end
    for (int s = 0; s <= 8 * RD; s++) begin
      if (s > 0) @(negedge clk);
      e_an = ~(8'h01 << ((s / RD) % 8));
      chk($sformatf("t6_scan%0d", s), bus.o_an, e_an);
    end

    // 6b: reset mid-conversion aborts, then force restarts conversion
    bus.i_quo = 8'h21;
    bus.i_rem = 8'h03;
    wait_rise(lat);
    chk("t6_lat", lat, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", bus.o_busy, 0);
    chk("t6_rst_an", bus.o_an, 8'hFE);
    chk("t6_rst_seg", bus.o_seg, 7'h40);
    exp_q.push_back(model(8'h21, 8'h03));
    rst = 1'b0;
    wait_rise(lat);
    chk("t6_relat", lat, 1);
    wait_fall(1, len);
    chk("t6_len", len, 17);
    scan_check("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
